// File: rtl/arb_pkg.sv
// Shared encodings for the data-memory port arbiter.
package arb_pkg;

  // Arbiter FSM: IDLE arbitrates per cycle, LOCKED keeps a debug burst on the port.
  typedef enum logic [0:0] {
    StIdle,
    StLocked
  } arb_state_e;

  // Which requester owns the memory port in the current cycle.
  typedef enum logic [1:0] {
    OwnNone,
    OwnCpu,
    OwnDbg
  } arb_owner_e;

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module arb_sat_counter #(
  parameter int unsigned Max = 4,
  localparam int unsigned W  = (Max < 1) ? 1 : $clog2(Max + 1)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear, or step towards Max and hold there.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != W'(Max))) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register, synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port data-memory arbiter between the CPU MEM stage and a debug/loader port.
// CPU normally wins; a starved debug request gets one slot after MAX_WAIT cycles, and
// a locked debug burst yields one forced CPU slot every LOCK_MAX debug grants.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned AW       = 5,
  parameter int unsigned DW       = 32,
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned LOCK_MAX = 8
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic          dbg_lock,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic [DW-1:0] dbg_rdata,
  output logic          dbg_valid,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned WaitW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam int unsigned LockW = (LOCK_MAX < 1) ? 1 : $clog2(LOCK_MAX + 1);

  arb_state_e       state_q, state_d;
  arb_owner_e       owner;
  logic [WaitW-1:0] wait_cnt;
  logic [LockW-1:0] lock_cnt;
  logic             wait_full, lock_full, locked, cpu_grant;
  logic             leave_lock, forced_cpu, wait_inc, wait_clr, lock_inc, lock_clr;
  logic [DW-1:0]    dbg_rdata_q;
  logic             dbg_valid_q;

  assign wait_full  = (wait_cnt == WaitW'(MAX_WAIT));
  assign lock_full  = (lock_cnt == LockW'(LOCK_MAX));
  assign locked     = (state_q == StLocked);
  assign cpu_grant  = (owner == OwnCpu);
  assign dbg_gnt    = (owner == OwnDbg);
  assign cpu_stall  = cpu_req & ~cpu_grant;

  assign leave_lock = locked & (~dbg_req | ~dbg_lock);
  // CPU winning while a locked burst is still requesting is the forced fairness slot.
  assign forced_cpu = locked & dbg_req & cpu_grant;

  assign wait_inc   = dbg_req & ~dbg_gnt;
  assign wait_clr   = dbg_gnt | ~dbg_req;
  assign lock_inc   = locked & dbg_gnt;
  assign lock_clr   = forced_cpu | leave_lock;

  // Grant decision and next FSM state.
  always_comb begin
    owner   = OwnNone;
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (cpu_req && dbg_req) begin
          owner = wait_full ? OwnDbg : OwnCpu;
        end else if (cpu_req) begin
          owner = OwnCpu;
        end else if (dbg_req) begin
          owner = OwnDbg;
        end
        if ((owner == OwnDbg) && dbg_lock) begin
          state_d = StLocked;
        end
      end
      StLocked: begin
        if (dbg_req) begin
          owner = (lock_full && cpu_req) ? OwnCpu : OwnDbg;
        end else if (cpu_req) begin
          owner = OwnCpu;
        end
        if (!dbg_req || !dbg_lock) begin
          state_d = StIdle;
        end
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  arb_sat_counter #(
    .Max (MAX_WAIT)
  ) u_wait_cnt (
    .clk_i  (Clock),
    .rst_ni (Resetn),
    .inc_i  (wait_inc),
    .clr_i  (wait_clr),
    .cnt_o  (wait_cnt)
  );

  arb_sat_counter #(
    .Max (LOCK_MAX)
  ) u_lock_cnt (
    .clk_i  (Clock),
    .rst_ni (Resetn),
    .inc_i  (lock_inc),
    .clr_i  (lock_clr),
    .cnt_o  (lock_cnt)
  );

  // Memory port mux; an idle port drives all zeros.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    cpu_rdata = '0;
    case (owner)
      OwnCpu: begin
        mem_we    = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        cpu_rdata = mem_rdata;
      end
      OwnDbg: begin
        mem_we    = dbg_we;
        mem_addr  = dbg_addr;
        mem_wdata = dbg_wdata;
      end
      default: ;
    endcase
  end

  // Debug read data capture; the data holds until the next debug read.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      dbg_rdata_q <= '0;
      dbg_valid_q <= 1'b0;
    end else begin
      dbg_valid_q <= dbg_gnt & ~dbg_we;
      if (dbg_gnt && !dbg_we) begin
        dbg_rdata_q <= mem_rdata;
      end
    end
  end

  assign dbg_rdata = dbg_rdata_q;
  assign dbg_valid = dbg_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations plus a
// cycle-by-cycle behavioural model of the arbitration rules.
module tb_mem_port_arbiter;

  localparam int AW       = 5;
  localparam int DW       = 32;
  localparam int MAX_WAIT = 4;
  localparam int LOCK_MAX = 8;

  logic          Clock = 1'b0;
  logic          Resetn;
  logic          cpu_req, cpu_we, dbg_req, dbg_we, dbg_lock;
  logic [AW-1:0] cpu_addr, dbg_addr;
  logic [DW-1:0] cpu_wdata, dbg_wdata;
  logic [DW-1:0] cpu_rdata, dbg_rdata, mem_wdata, mem_rdata;
  logic          cpu_stall, dbg_gnt, dbg_valid, mem_we;
  logic [AW-1:0] mem_addr;

  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  mem_port_arbiter #(
    .AW       (AW),
    .DW       (DW),
    .MAX_WAIT (MAX_WAIT),
    .LOCK_MAX (LOCK_MAX)
  ) dut (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .dbg_req   (dbg_req),
    .dbg_we    (dbg_we),
    .dbg_lock  (dbg_lock),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .dbg_gnt   (dbg_gnt),
    .dbg_rdata (dbg_rdata),
    .dbg_valid (dbg_valid),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Memory environment: asynchronous read, write on the rising edge.
  logic [DW-1:0] mem [2**AW];
  assign mem_rdata = mem[mem_addr];
  always @(posedge Clock) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model state.
  bit            m_locked = 0;
  int            m_wait   = 0;
  int            m_lock   = 0;
  logic [DW-1:0] m_rdata  = '0;
  bit            m_valid  = 0;

  // Compare every cycle at the falling edge, then advance the model to the next edge.
  always @(negedge Clock) begin
    bit            e_cpu, e_dbg, leaving;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_crd;
    e_cpu = 0;
    e_dbg = 0;
    if (!m_locked) begin
      if (cpu_req && dbg_req) begin
        if (m_wait == MAX_WAIT) e_dbg = 1; else e_cpu = 1;
      end else if (cpu_req) e_cpu = 1;
      else if (dbg_req) e_dbg = 1;
    end else begin
      if (dbg_req) begin
        if (m_lock == LOCK_MAX && cpu_req) e_cpu = 1; else e_dbg = 1;
      end else if (cpu_req) e_cpu = 1;
    end
    e_we    = e_cpu ? cpu_we    : (e_dbg ? dbg_we    : 1'b0);
    e_addr  = e_cpu ? cpu_addr  : (e_dbg ? dbg_addr  : '0);
    e_wdata = e_cpu ? cpu_wdata : (e_dbg ? dbg_wdata : '0);
    e_crd   = e_cpu ? mem[cpu_addr] : '0;

    check("model_dbg_gnt",   dbg_gnt,   e_dbg);
    check("model_cpu_stall", cpu_stall, cpu_req && !e_cpu);
    check("model_mem_we",    mem_we,    e_we);
    check("model_mem_addr",  mem_addr,  e_addr);
    check("model_mem_wdata", mem_wdata, e_wdata);
    check("model_cpu_rdata", cpu_rdata, e_crd);
    check("model_dbg_rdata", dbg_rdata, m_rdata);
    check("model_dbg_valid", dbg_valid, m_valid);

    if (!Resetn) begin
      m_locked = 0;
      m_wait   = 0;
      m_lock   = 0;
      m_rdata  = '0;
      m_valid  = 0;
    end else begin
      leaving = m_locked && (!dbg_req || !dbg_lock);
      if (dbg_req && !e_dbg) m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT;
      else m_wait = 0;
      if ((m_locked && dbg_req && e_cpu) || leaving) m_lock = 0;
      else if (m_locked && e_dbg) m_lock = (m_lock < LOCK_MAX) ? m_lock + 1 : LOCK_MAX;
      if (!m_locked) m_locked = e_dbg && dbg_lock;
      else m_locked = !leaving;
      if (e_dbg && !dbg_we) m_rdata = mem[dbg_addr];
      m_valid = e_dbg && !dbg_we;
    end
  end

  task automatic next_cycle();
    @(posedge Clock);
    #1;
  endtask

  task automatic set_cpu(input logic req, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata);
    cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
  endtask

  task automatic set_dbg(input logic req, input logic we, input logic lock,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    dbg_req = req; dbg_we = we; dbg_lock = lock; dbg_addr = addr; dbg_wdata = wdata;
  endtask

  // Expected dbg_gnt per cycle of a locked burst against a continuous CPU request.
  logic [15:0] burst_gnt;

  initial begin
    Resetn = 1'b0;
    set_cpu(1'b0, 1'b0, 5'd0, 32'h0);
    set_dbg(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    next_cycle();
    next_cycle();
    Resetn = 1'b1;
    #1;
    check("reset_dbg_valid", dbg_valid, 1'b0);
    check("reset_dbg_rdata", dbg_rdata, 32'h0);
    check("reset_mem_we",    mem_we,    1'b0);
    check("reset_dbg_gnt",   dbg_gnt,   1'b0);

    // CPU-only store.
    next_cycle();
    set_cpu(1'b1, 1'b1, 5'd3, 32'hDEADBEEF);
    #1;
    check("cpu_only_mem_we",    mem_we,    1'b1);
    check("cpu_only_mem_addr",  mem_addr,  5'd3);
    check("cpu_only_mem_wdata", mem_wdata, 32'hDEADBEEF);
    check("cpu_only_stall",     cpu_stall, 1'b0);

    // Debug-only write preloads word 7.
    next_cycle();
    set_cpu(1'b0, 1'b0, 5'd0, 32'h0);
    set_dbg(1'b1, 1'b1, 1'b0, 5'd7, 32'h12345678);
    #1;
    check("dbg_wr_gnt",      dbg_gnt,  1'b1);
    check("dbg_wr_mem_addr", mem_addr, 5'd7);

    // cpu_we without cpu_req is ignored; a debug write leaves no valid pulse.
    next_cycle();
    set_cpu(1'b0, 1'b1, 5'd9, 32'hFFFF0000);
    set_dbg(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    #1;
    check("no_req_mem_we",    mem_we,    1'b0);
    check("no_req_mem_addr",  mem_addr,  5'd0);
    check("no_req_mem_wdata", mem_wdata, 32'h0);
    check("wr_no_valid",      dbg_valid, 1'b0);

    // Contention: CPU cycles 0-3, debug cycle 4.
    for (int c = 0; c < 5; c++) begin
      next_cycle();
      if (c == 0) begin
        set_cpu(1'b1, 1'b0, 5'd7, 32'h0);
        set_dbg(1'b1, 1'b0, 1'b0, 5'd3, 32'h0);
      end
      #1;
      check($sformatf("contend_gnt_c%0d", c),   dbg_gnt,   c == 4);
      check($sformatf("contend_stall_c%0d", c), cpu_stall, c == 4);
      if (c < 4) check($sformatf("contend_cpu_rdata_c%0d", c), cpu_rdata, 32'h12345678);
    end
    next_cycle();
    set_dbg(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    #1;
    check("contend_dbg_valid", dbg_valid, 1'b1);
    check("contend_dbg_rdata", dbg_rdata, 32'hDEADBEEF);
    check("contend_after_gnt", dbg_gnt,   1'b0);

    // Debug read of word 7.
    next_cycle();
    set_cpu(1'b0, 1'b0, 5'd0, 32'h0);
    set_dbg(1'b1, 1'b0, 1'b0, 5'd7, 32'h0);
    #1;
    check("dbg_rd_gnt", dbg_gnt, 1'b1);
    next_cycle();
    set_dbg(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    #1;
    check("dbg_rd_valid", dbg_valid, 1'b1);
    check("dbg_rd_data",  dbg_rdata, 32'h12345678);
    next_cycle();
    #1;
    check("dbg_rd_valid_drop", dbg_valid, 1'b0);
    check("dbg_rd_data_hold",  dbg_rdata, 32'h12345678);

    // Locked burst against a continuous CPU request (c0 is the LSB).
    burst_gnt = 16'b1101_1111_1111_0000;
    for (int c = 0; c < 16; c++) begin
      next_cycle();
      if (c == 0) begin
        set_cpu(1'b1, 1'b0, 5'd3, 32'h0);
        set_dbg(1'b1, 1'b0, 1'b1, 5'd7, 32'h0);
      end
      #1;
      check($sformatf("burst_gnt_c%0d", c), dbg_gnt, burst_gnt[c]);
    end

    // Reset for one cycle mid-burst.
    next_cycle();
    Resetn = 1'b0;
    #1;
    check("rst_burst_gnt_in_reset", dbg_gnt, 1'b1);
    next_cycle();
    Resetn = 1'b1;
    #1;
    check("rst_burst_gnt",   dbg_gnt,   1'b0);
    check("rst_burst_stall", cpu_stall, 1'b0);
    check("rst_burst_valid", dbg_valid, 1'b0);
    check("rst_burst_rdata", dbg_rdata, 32'h0);

    // Free-running mix covered by the model: lock, unlock via dbg_lock, writes, idle.
    for (int c = 0; c < 24; c++) begin
      next_cycle();
      set_cpu(c[0], c[1], 5'(c), 32'hA000_0000 + 32'(c));
      set_dbg(1'b1, c[2], (c < 12), 5'(c + 11), 32'h5000_0000 + 32'(c));
    end
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      set_cpu(1'b0, 1'b0, 5'd0, 32'h0);
      set_dbg(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    end
    next_cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter AW, default 5, data-memory word-address width.
REQ-002 SHALL have parameter DW, default 32, data width.
REQ-003 SHALL have parameter MAX_WAIT, default 4, debug-port starvation limit in cycles.
REQ-004 SHALL have parameter LOCK_MAX, default 8, maximum consecutive locked debug grants before one CPU slot is forced.
REQ-005 SHALL have ports (name, direction, width, meaning):
 Clock  in  1  sole clock, rising edge
 Resetn  in  1  reset, synchronous, active-low
 cpu_req  in  1  MEM-stage access pending (load or store)
 cpu_we  in  1  CPU store
 cpu_addr  in  AW  CPU word address
 cpu_wdata  in  DW  CPU store data
 cpu_rdata  out  DW  CPU load data, same cycle as grant
 cpu_stall  out  1  freeze PC/IR/pipeline registers this cycle
 dbg_req  in  1  debug/loader access pending, held until dbg_gnt
 dbg_we  in  1  debug write
 dbg_lock  in  1  request burst ownership
 dbg_addr  in  AW  debug word address
 dbg_wdata  in  DW  debug write data
 dbg_gnt  out  1  debug access performed this cycle
 dbg_rdata  out  DW  registered debug read data
 dbg_valid  out  1  dbg_rdata valid, one-cycle pulse
 mem_we  out  1  memory write enable
 mem_addr  out  AW  memory address
 mem_wdata  out  DW  memory write data
 mem_rdata  in  DW  memory asynchronous read data

Function
REQ-006 SHALL perform at most one memory access per cycle; the grant is combinational from the current state and requests.
REQ-007 SHALL use FSM states IDLE and LOCKED.
REQ-008 In IDLE, SHALL grant as follows: CPU only requesting -> CPU; debug only requesting -> debug; both requesting -> debug if wait_cnt==MAX_WAIT, else CPU.
REQ-009 In LOCKED with dbg_req=1, SHALL grant debug, unless lock_cnt==LOCK_MAX and cpu_req=1, in which case SHALL grant CPU for that single cycle.
REQ-010 SHALL transition IDLE->LOCKED at an edge where dbg_gnt=1 and dbg_lock=1.
REQ-011 SHALL transition LOCKED->IDLE at an edge where dbg_req=0 or dbg_lock=0.
REQ-012 SHALL increment lock_cnt (saturating at LOCK_MAX) on each locked debug grant; SHALL clear it on a forced CPU slot or on leaving LOCKED.
REQ-013 SHALL increment wait_cnt (saturating at MAX_WAIT) each cycle dbg_req=1 and dbg_gnt=0; SHALL clear it when dbg_gnt=1 or dbg_req=0.
REQ-014 SHALL drive cpu_stall = cpu_req & ~cpu_grant, combinationally.
REQ-015 SHALL drive mem_we, mem_addr and mem_wdata from the granted requester; with no grant, SHALL drive all three to 0.
REQ-016 SHALL drive cpu_rdata = mem_rdata when CPU is granted, else 0.
REQ-017 On an edge with dbg_gnt=1 and dbg_we=0, SHALL register mem_rdata into dbg_rdata and pulse dbg_valid=1 for the next cycle only.
REQ-018 dbg_rdata SHALL hold its value between reads.
REQ-019 cpu_we/dbg_we SHALL be ignored when the matching req=0.
REQ-020 dbg_lock without a grant SHALL have no effect.

Reset
REQ-021 While Resetn=0 at an edge, SHALL set state=IDLE, wait_cnt=0, lock_cnt=0, dbg_rdata=0, dbg_valid=0.
REQ-022 A reset mid-burst SHALL drop the lock and discard any pending dbg_valid.
REQ-023 Combinational outputs SHALL follow REQ-014..016 during reset; no write SHALL be suppressed.

Structure
REQ-024 A shared package arb_pkg SHALL hold the state encoding (IDLE, LOCKED) and the owner encoding (NONE, CPU, DBG).
REQ-025 SHALL instantiate one sub-module, arb_sat_counter (parameterised saturating counter with inc/clr), used for both wait_cnt and lock_cnt.

Verification
REQ-026 CPU only: cpu_req=1, we=1, addr=3, wdata=0xDEADBEEF -> same cycle mem_we=1, mem_addr=3, cpu_stall=0.
REQ-027 Contention: both requesting continuously, MAX_WAIT=4 -> CPU granted cycles 0-3, debug granted cycle 4, cpu_stall=1 in cycle 4 only.
REQ-028 Debug read: memory[7]=0x12345678, dbg read addr=7 -> dbg_gnt same cycle, next cycle dbg_valid=1 and dbg_rdata=0x12345678, then dbg_valid=0.
REQ-029 Lock burst: dbg_lock=1 with cpu_req held high, LOCK_MAX=8 -> 1 IDLE grant plus 8 locked debug grants, then 1 forced CPU slot, then debug resumes.
REQ-030 Reset mid-burst: Resetn=0 for 1 cycle while LOCKED -> state IDLE, dbg_valid=0, and the next contention cycle grants CPU.
